// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between EX/MEM and MEMWB.
//
// Loads and stores become one req/ack transaction on the data bus. The
// pipeline is stalled from issue until the bus acknowledges. Load data comes
// back shifted down to bit 0, so MEMWB can sign- or zero-extend it from the
// low bits. Non-memory instructions pass straight through with no latency.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   ex_valid                   EX/MEM holds a valid instruction
//   mem_read, mem_write        load / store (never both)
//   mem_size                   0 byte, 1 half, 2 word, 3 treated as word
//   wbs_in, rdn_in, alu_in     writeback select, dest reg, ALU result/address
//   st_data                    right-aligned store data
//   d_req, d_we, d_addr,
//   d_be, d_wdata              registered data-bus request
//   d_ack, d_rdata             data-bus completion and read data
//   stall                      hold PC, IF/ID, ID/EX and EX/MEM
//   misalign                   one-cycle misaligned-access flag
//   wbs, rdn, alu_out, mrd     results forwarded to MEMWB
module mem_access #(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ex_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [1:0]          mem_size,
  input  logic [2:0]          wbs_in,
  input  logic [4:0]          rdn_in,
  input  logic [WordSize-1:0] alu_in,
  input  logic [WordSize-1:0] st_data,
  output logic                d_req,
  output logic                d_we,
  output logic [WordSize-1:0] d_addr,
  output logic [3:0]          d_be,
  output logic [WordSize-1:0] d_wdata,
  input  logic                d_ack,
  input  logic [WordSize-1:0] d_rdata,
  output logic                stall,
  output logic                misalign,
  output logic [2:0]          wbs,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] alu_out,
  output logic [WordSize-1:0] mrd
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_next;

  logic                mem_op;
  logic                mis_op;
  logic                start;
  logic [3:0]          be_calc;
  logic [WordSize-1:0] wdata_calc;

  logic [1:0]          off_q;
  logic [2:0]          wbs_q;
  logic [4:0]          rdn_q;
  logic [WordSize-1:0] alu_q;
  logic [WordSize-1:0] mrd_q;

  assign mem_op = ex_valid & (mem_read | mem_write);
  assign start  = (state == IDLE) & mem_op & ~mis_op;

  // Byte-lane enables, replicated store data and alignment check.
  always_comb begin
    be_calc    = '0;
    wdata_calc = '0;
    mis_op     = 1'b0;
    case (mem_size)
      2'd0: begin
        be_calc    = 4'b0001 << alu_in[1:0];
        wdata_calc = {4{st_data[7:0]}};
      end
      2'd1: begin
        be_calc    = 4'b0011 << alu_in[1:0];
        wdata_calc = {2{st_data[15:0]}};
        mis_op     = alu_in[0];
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = st_data;
        mis_op     = |alu_in[1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      d_req   <= 1'b0;
      d_we    <= 1'b0;
      d_addr  <= '0;
      d_be    <= '0;
      d_wdata <= '0;
      off_q   <= '0;
      wbs_q   <= '0;
      rdn_q   <= '0;
      alu_q   <= '0;
      mrd_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            d_req   <= 1'b1;
            d_we    <= mem_write;
            d_addr  <= {alu_in[WordSize-1:2], 2'b00};
            d_be    <= be_calc;
            d_wdata <= wdata_calc;
            off_q   <= alu_in[1:0];
            wbs_q   <= wbs_in;
            rdn_q   <= rdn_in;
            alu_q   <= alu_in;
          end
        end
        WAIT: begin
          // d_we still reflects the latched op, so it doubles as store flag.
          if (d_ack) begin
            d_req <= 1'b0;
            mrd_q <= d_we ? '0 : (d_rdata >> {off_q, 3'b000});
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    misalign   = 1'b0;
    wbs        = 3'd3;
    rdn        = '0;
    alu_out    = '0;
    mrd        = '0;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          if (mis_op) begin
            misalign = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = WAIT;
          end
        end else begin
          rdn     = ex_valid ? rdn_in : '0;
          wbs     = wbs_in;
          alu_out = alu_in;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (d_ack) state_next = RESP;
      end
      RESP: begin
        rdn        = rdn_q;
        wbs        = wbs_q;
        alu_out    = alu_q;
        mrd        = mrd_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
